tile_stream_source: RTL

Valid/ready stream transmitter that reads a contiguous burst of words from a synchronous single-port memory and emits them as a packetised stream toward the systolic array's skid-buffered input pipeline. Decouples the fixed 1-cycle memory read latency from downstream backpressure using a 3-entry output queue, sustaining one beat per cycle with no combinational path from `m_ready` to the memory port. Sits between tile SRAM and the array feeder.

---
 rtl/tile_stream_source.sv | 121 ++++++++++++
 1 files changed

// File: rtl/tile_stream_source.sv
// tile_stream_source: burst reader from 1-cycle-latency SRAM into a valid/ready stream via a 3-entry queue.
// Revision: 1.0 - initial release
`default_nettype none

module tile_stream_source #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued;
  logic [LEN_WIDTH-1:0]  beats;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] q_data [3];
  logic [2:0]            q_last;
  logic [1:0]            head;
  logic [1:0]            tail;
  logic [1:0]            occ;
  logic [2:0]            occ_sum;
  logic                  push;
  logic                  pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Issue decision uses only registered state, so m_ready never reaches the memory port.
  assign occ_sum  = {1'b0, occ} + {2'b00, inflight};
  assign mem_en   = (state == RUN) && (issued < len_q) && (occ_sum < 3'd3);
  assign mem_addr = base_q + ADDR_WIDTH'(issued);

  assign push     = inflight;
  assign m_valid  = (occ != 2'd0);
  assign m_data   = q_data[head];
  assign m_last   = m_valid & q_last[head];
  assign pop      = m_valid & m_ready;

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued   <= '0;
      beats    <= '0;
      inflight <= 1'b0;
      q_last   <= '0;
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      for (int i = 0; i < 3; i++) q_data[i] <= '0;
    end else begin
      inflight <= mem_en;
      if (mem_en) issued <= issued + LEN_ONE;

      if (push) begin
        q_data[tail] <= mem_rdata;
        q_last[tail] <= (beats == len_q - LEN_ONE);
        tail         <= ptr_inc(tail);
        beats        <= beats + LEN_ONE;
      end
      if (pop) head <= ptr_inc(head);

      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              base_q <= base_addr;
              len_q  <= len;
              issued <= '0;
              beats  <= '0;
              state  <= RUN;
            end else begin
              state  <= DONE;
            end
          end
        end
        RUN:     if (pop && m_last) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
